// File: rtl/merge_seq_if.sv
// ============================================================================
// Module      : merge_seq_if
// Description : Handshake and strobe bundle between the merge sequencer and
//               its requester / merge datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface merge_seq_if;
    logic       start;
    logic [1:0] mod;
    logic       busy;
    logic       done;
    logic [1:0] s;
    logic [1:0] ld_4to8;
    logic [1:0] ld_8to16;
    logic [1:0] ld_16to32;
    logic [1:0] ld_32to64;
    logic [1:0] ld_64to128;
    logic [1:0] ld_128to256;

    modport master (
        output start, mod,
        input  busy, done, s,
        input  ld_4to8, ld_8to16, ld_16to32, ld_32to64, ld_64to128, ld_128to256
    );

    modport slave (
        input  start, mod,
        output busy, done, s,
        output ld_4to8, ld_8to16, ld_16to32, ld_32to64, ld_64to128, ld_128to256
    );
endinterface

`default_nettype wire

// File: rtl/merge_seq_ctrl.sv
// ============================================================================
// Module      : merge_seq_ctrl
// Description : Walks the cascaded merge stages a modulation mode needs,
//               issuing A/B load strobes and settle gaps, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module merge_seq_ctrl #(
    parameter int SETTLE = 2,
    parameter int CW     = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    merge_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LDA    = 3'd1,
        ST_LDB    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam logic [CW-1:0] C_SETTLE_LD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

    state_t          r_state;
    logic [5:0][1:0] r_ld;
    logic            r_busy;
    logic            r_done;
    logic [1:0]      r_s;
    logic [1:0]      r_mode;
    logic [2:0]      r_stage;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      w_last;
    logic [2:0]      w_next;
    logic            w_adv;

    always_comb begin
        w_last = 3'd0;
        case (r_mode)
            2'd0:    w_last = 3'd0;
            2'd1:    w_last = 3'd1;
            2'd2:    w_last = 3'd3;
            default: w_last = 3'd5;
        endcase
    end

    assign w_next = r_stage + 3'd1;
    // A stage is finished once its settle gap expires, or straight after LDB when there is no gap.
    assign w_adv  = ((r_state == ST_LDB) && (SETTLE == 0)) ||
                    ((r_state == ST_SETTLE) && (r_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ld    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= 2'b00;
            r_mode  <= 2'b00;
            r_stage <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_ld   <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_s     <= bus.mod;
                        r_mode  <= bus.mod;
                        r_stage <= 3'd0;
                        r_busy  <= 1'b1;
                        r_ld[0] <= 2'b01;
                        r_state <= ST_LDA;
                    end
                end
                ST_LDA: begin
                    r_ld[r_stage] <= 2'b10;
                    r_state       <= ST_LDB;
                end
                ST_LDB: begin
                    if (SETTLE > 0) begin
                        r_cnt   <= C_SETTLE_LD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_adv) begin
                if (r_stage == w_last) begin
                    r_done  <= 1'b1;
                    r_state <= ST_FIN;
                end else begin
                    r_stage      <= w_next;
                    r_ld[w_next] <= 2'b01;
                    r_state      <= ST_LDA;
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.s           = r_s;
    assign bus.ld_4to8     = r_ld[0];
    assign bus.ld_8to16    = r_ld[1];
    assign bus.ld_16to32   = r_ld[2];
    assign bus.ld_32to64   = r_ld[3];
    assign bus.ld_64to128  = r_ld[4];
    assign bus.ld_128to256 = r_ld[5];

endmodule

`default_nettype wire

// File: tb/tb_merge_seq_ctrl.sv
// ============================================================================
// Module      : tb_merge_seq_ctrl
// Description : Self-checking bench for merge_seq_ctrl (SETTLE=2 and SETTLE=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_merge_seq_ctrl;

    typedef struct packed {
        logic [11:0] ld;
        logic        busy;
        logic        done;
        logic [1:0]  s;
    } obs_t;

    typedef struct {
        int         sel;
        logic [1:0] mod;
        int         lat;
        int         strobes;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    merge_seq_if bus_a ();
    merge_seq_if bus_b ();

    merge_seq_ctrl #(.SETTLE(2), .CW(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    merge_seq_ctrl #(.SETTLE(0), .CW(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int   checks = 0;
    int   errors = 0;

    obs_t       tr [2][0:31];
    int         rd [2];
    int         wr [2];
    logic [1:0] ms [2];
    bit         mbusy [2];

    function automatic obs_t observe(input int i);
        obs_t o;
        if (i == 0)
            o = {bus_a.ld_128to256, bus_a.ld_64to128, bus_a.ld_32to64, bus_a.ld_16to32,
                 bus_a.ld_8to16, bus_a.ld_4to8, bus_a.busy, bus_a.done, bus_a.s};
        else
            o = {bus_b.ld_128to256, bus_b.ld_64to128, bus_b.ld_32to64, bus_b.ld_16to32,
                 bus_b.ld_8to16, bus_b.ld_4to8, bus_b.busy, bus_b.done, bus_b.s};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the whole output trace of one accepted request, built from the stage rules.
    task automatic model_accept(input int i, input logic [1:0] md);
        int   n;
        int   settle;
        obs_t e;
        n      = (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 6;
        settle = (i == 0) ? 2 : 0;
        rd[i]  = 0;
        wr[i]  = 0;
        ms[i]  = md;
        for (int k = 0; k < n; k++) begin
            e = '{ld: 12'b01 << (2 * k), busy: 1'b1, done: 1'b0, s: md};
            tr[i][wr[i]++] = e;
            e.ld = 12'b10 << (2 * k);
            tr[i][wr[i]++] = e;
            for (int j = 0; j < settle; j++) begin
                e.ld = '0;
                tr[i][wr[i]++] = e;
            end
        end
        e = '{ld: 12'b0, busy: 1'b1, done: 1'b1, s: md};
        tr[i][wr[i]++] = e;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rd[i]    = 0;
            wr[i]    = 0;
            ms[i]    = 2'b00;
            mbusy[i] = 1'b0;
        end
    endtask

    // Called just after a falling edge: drive inputs, advance one clock, compare both DUTs.
    task automatic step(input bit st_a, input logic [1:0] md_a, input bit st_b, input logic [1:0] md_b);
        obs_t e;
        bus_a.start = st_a;
        bus_a.mod   = md_a;
        bus_b.start = st_b;
        bus_b.mod   = md_b;
        if (!mbusy[0] && st_a) model_accept(0, md_a);
        if (!mbusy[1] && st_b) model_accept(1, md_b);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rd[i] < wr[i]) e = tr[i][rd[i]++];
            else               e = '{ld: 12'b0, busy: 1'b0, done: 1'b0, s: ms[i]};
            mbusy[i] = e.busy;
            check((i == 0) ? "trace_settle2" : "trace_settle0", 32'(observe(i)), 32'(e));
        end
        @(negedge clk);
    endtask

    vec_t vecs [8];

    initial begin
        int   lat;
        int   strobes;
        int   dones;
        bit   seen;
        obs_t o;

        vecs[0] = '{0, 2'd0, 5,  2};
        vecs[1] = '{0, 2'd1, 9,  4};
        vecs[2] = '{0, 2'd2, 17, 8};
        vecs[3] = '{0, 2'd3, 25, 12};
        vecs[4] = '{1, 2'd0, 3,  2};
        vecs[5] = '{1, 2'd1, 5,  4};
        vecs[6] = '{1, 2'd2, 9,  8};
        vecs[7] = '{1, 2'd3, 13, 12};

        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.mod   = 2'b00;
        bus_b.start = 1'b0;
        bus_b.mod   = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 32'(observe(0)), 32'd0);
        check("reset_b", 32'(observe(1)), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: one request per record, measure latency, strobe count and select.
        foreach (vecs[v]) begin
            step(vecs[v].sel == 0, vecs[v].mod, vecs[v].sel == 1, vecs[v].mod);
            lat     = 1;
            strobes = 0;
            seen    = 1'b0;
            o = observe(vecs[v].sel);
            if (o.ld != 0) strobes++;
            while (!o.done && lat < 40) begin
                step(1'b0, 2'b00, 1'b0, 2'b00);
                lat++;
                o = observe(vecs[v].sel);
                if (o.ld != 0) strobes++;
            end
            seen = o.done;
            check("tbl_done_seen", 32'(seen), 32'd1);
            check("tbl_latency", 32'(lat), 32'(vecs[v].lat));
            check("tbl_strobes", 32'(strobes), 32'(vecs[v].strobes));
            check("tbl_select", 32'(o.s), 32'(vecs[v].mod));
            step(1'b0, 2'b00, 1'b0, 2'b00);
        end

        // Busy rejection: second requests at cycle 2 and at the done cycle are dropped.
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            step(c == 0 || c == 2 || c == 9, (c == 0) ? 2'd1 : 2'd3, 1'b0, 2'b00);
            if (observe(0).done) dones++;
        end
        check("busy_rej_s", 32'(bus_a.s), 32'd1);
        check("busy_rej_dones", 32'(dones), 32'd1);

        // Back-to-back: request on the cycle right after done behaves like a fresh run.
        step(1'b1, 2'd1, 1'b0, 2'b00);
        lat = 1;
        while (!observe(0).done && lat < 40) begin
            step(1'b0, 2'b00, 1'b0, 2'b00);
            lat++;
        end
        check("b2b_latency", 32'(lat), 32'd9);
        step(1'b0, 2'b00, 1'b0, 2'b00);

        // Reset mid-run: outputs clear asynchronously, no done appears afterwards.
        step(1'b1, 2'd3, 1'b1, 2'd2);
        repeat (4) step(1'b0, 2'b00, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        check("async_reset_a", 32'(observe(0)), 32'd0);
        check("async_reset_b", 32'(observe(1)), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 2'b00, 1'b0, 2'b00);
            if (observe(0).done || observe(1).done) dones++;
        end
        check("post_reset_dones", 32'(dones), 32'd0);

        // Random requests and modes on both builds against the reference traces.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
